display_out_sequencer: RTL

- Sits between the CPU output-port decode and the numeric display unit. Queues CPU "set format mode" and "emit value" writes in a small FIFO.
- Replays queued writes to the display one at a time as single-cycle load strobes with a stable bus byte.
- After each emitted value, waits for the host/emulator to acknowledge that it consumed the formatted text.
- Decouples CPU store timing from host consumption, so values are never overwritten before they are read.

---
 rtl/display_out_sequencer_if.sv | 38 +++
 rtl/display_out_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/display_out_sequencer_if.sv
// CPU/host-facing signal bundle of the display output sequencer.
// DISPSEQ_ACK_TIMEOUT_EN adds the sticky timeout flag.
interface display_out_sequencer_if;
  logic [7:0] main_bus;
  logic       wr_val;
  logic       wr_mode;
  logic       host_ack;
  logic [7:0] disp_bus;
  logic       disp_load_val;
  logic       disp_load_mode;
  logic       fifo_full;
  logic       fifo_empty;
  logic       busy;
  logic       overflow;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
  logic       timeout;

  modport master (
    output main_bus, wr_val, wr_mode, host_ack,
    input  disp_bus, disp_load_val, disp_load_mode, fifo_full, fifo_empty, busy, overflow,
           timeout
  );
  modport slave (
    input  main_bus, wr_val, wr_mode, host_ack,
    output disp_bus, disp_load_val, disp_load_mode, fifo_full, fifo_empty, busy, overflow,
           timeout
  );
`else
  modport master (
    output main_bus, wr_val, wr_mode, host_ack,
    input  disp_bus, disp_load_val, disp_load_mode, fifo_full, fifo_empty, busy, overflow
  );
  modport slave (
    input  main_bus, wr_val, wr_mode, host_ack,
    output disp_bus, disp_load_val, disp_load_mode, fifo_full, fifo_empty, busy, overflow
  );
`endif
endinterface

// File: rtl/display_out_sequencer.sv
// Queues CPU mode/value writes and replays them to the display as one-cycle load strobes.
// Optional ack-wait timeout enabled with DISPSEQ_ACK_TIMEOUT_EN.
module display_out_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    reset,
  display_out_sequencer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_e;

  state_e          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            kind_q, kind_d;
  logic [7:0]      disp_bus_q, disp_bus_d;
  logic            overflow_q, overflow_d;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
  logic [15:0]     tcnt_q, tcnt_d;
  logic            timeout_q, timeout_d;
`endif

  logic [CntW-1:0] free_slots;
  logic            push_one, push_two, drop, pop;
  logic [8:0]      head;

  // Free-slot check uses the occupancy before any same-cycle pop.
  always_comb begin
    free_slots = CntW'(DEPTH) - count_q;
    push_one   = 1'b0;
    push_two   = 1'b0;
    drop       = 1'b0;
    if (bus.wr_val && bus.wr_mode) begin
      if (free_slots >= CntW'(2)) push_two = 1'b1;
      else                        drop     = 1'b1;
    end else if (bus.wr_val || bus.wr_mode) begin
      if (free_slots != '0) push_one = 1'b1;
      else                  drop     = 1'b1;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign pop  = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push_two) begin
      wr_ptr_d = wr_ptr_q + PtrW'(2);
      count_d  = count_d + CntW'(2);
    end else if (push_one) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d  = count_d + CntW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d  = count_d - CntW'(1);
    end
  end

  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_two) begin
      mem_q[wr_ptr_q]              <= {1'b0, bus.main_bus};
      mem_q[wr_ptr_q + PtrW'(1)]   <= {1'b1, bus.main_bus};
    end else if (push_one) begin
      mem_q[wr_ptr_q]              <= {bus.wr_val, bus.main_bus};
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    disp_bus_d = disp_bus_q;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          disp_bus_d = head[7:0];
          kind_d     = head[8];
          state_d    = StIssue;
        end
      end
      StIssue: begin
        state_d = kind_q ? StWaitAck : StIdle;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      StWaitAck: begin
        if (bus.host_ack) begin
          state_d = StIdle;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
        end else if (tcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      kind_q     <= 1'b0;
      disp_bus_q <= 8'h00;
      overflow_q <= 1'b0;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
      tcnt_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      kind_q     <= kind_d;
      disp_bus_q <= disp_bus_d;
      overflow_q <= overflow_d;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.disp_bus       = disp_bus_q;
  assign bus.disp_load_val  = (state_q == StIssue) && kind_q;
  assign bus.disp_load_mode = (state_q == StIssue) && !kind_q;
  assign bus.fifo_full      = (count_q == CntW'(DEPTH));
  assign bus.fifo_empty     = (count_q == '0);
  assign bus.busy           = (state_q != StIdle) || (count_q != '0);
  assign bus.overflow       = overflow_q;
`ifdef DISPSEQ_ACK_TIMEOUT_EN
  assign bus.timeout        = timeout_q;
`endif
endmodule
